// File: rtl/upc_pkg.sv
// Shared definitions for the UPC checkout controller: FSM states and default item masks.
package upc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ALARM = 1'b1
  } state_t;

  // Default masks for 3-bit codes: discount on codes 2,3,5,6,7; theft tags on codes 0,4,5.
  localparam logic [7:0] DISC_MASK_DEF  = 8'hEC;
  localparam logic [7:0] THEFT_MASK_DEF = 8'h31;

endpackage

// File: rtl/upc_checkout_sat_counter.sv
// Saturating up-counter; a clear and an increment in the same cycle yield a count of one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? W'(1) : '0;
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/upc_checkout.sv
// Checkout scanner controller: counts sales and discounts, raises a theft alarm on
// unmarked tagged items and blocks further scans until the clerk acknowledges it.
//
//   state | meaning
//   IDLE  | accepting scans, clear_total honoured
//   ALARM | theft detected, scans and clear_total ignored until alarm_ack
module upc_checkout
  import upc_pkg::*;
#(
  parameter int                     UPC_W      = 3,
  parameter int                     CNT_W      = 8,
  parameter logic [2**UPC_W-1:0]    DISC_MASK  = (2**UPC_W)'(DISC_MASK_DEF),
  parameter logic [2**UPC_W-1:0]    THEFT_MASK = (2**UPC_W)'(THEFT_MASK_DEF)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scan_valid,
  output logic             scan_ready,
  input  logic [UPC_W-1:0] upc,
  input  logic             mark,
  input  logic             alarm_ack,
  input  logic             clear_total,
  output logic [CNT_W-1:0] item_count,
  output logic [CNT_W-1:0] disc_count,
  output logic [CNT_W-1:0] theft_count,
  output logic             alarm,
  output logic [UPC_W-1:0] last_upc,
  output logic             last_disc
);

  state_t r_state;

  logic w_accept;
  logic w_theft;
  logic w_disc_item;
  logic w_clr;
  logic w_inc_item;
  logic w_inc_disc;
  logic w_inc_theft;

  assign scan_ready  = (r_state == IDLE);
  assign alarm       = (r_state == ALARM);

  assign w_accept    = scan_valid && scan_ready;
  assign w_theft     = THEFT_MASK[upc] && !mark;
  assign w_disc_item = DISC_MASK[upc];
  assign w_clr       = clear_total && (r_state == IDLE);
  assign w_inc_item  = w_accept && !w_theft;
  assign w_inc_disc  = w_inc_item && w_disc_item;
  assign w_inc_theft = w_accept && w_theft;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_inc_theft) r_state <= ALARM;
        ALARM:   if (alarm_ack)   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Last-scan info is recorded for thefts too, so the clerk can see what tripped the alarm.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_upc  <= '0;
      last_disc <= 1'b0;
    end else if (w_accept) begin
      last_upc  <= upc;
      last_disc <= w_disc_item;
    end
  end

  sat_counter #(.W(CNT_W)) u_item_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_clr),
    .inc     (w_inc_item),
    .q       (item_count)
  );

  sat_counter #(.W(CNT_W)) u_disc_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_clr),
    .inc     (w_inc_disc),
    .q       (disc_count)
  );

  sat_counter #(.W(CNT_W)) u_theft_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_clr),
    .inc     (w_inc_theft),
    .q       (theft_count)
  );

endmodule

// File: tb/tb_upc_checkout.sv
// Bench for upc_checkout: directed scenarios plus random scans, with a default-width
// instance and a 2-bit-counter instance driven by the same stimulus.
module tb_upc_checkout;

  localparam logic [7:0] DISC  = 8'hEC;
  localparam logic [7:0] THEFT = 8'h31;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       scan_valid = 1'b0;
  logic [2:0] upc = 3'd0;
  logic       mark = 1'b0;
  logic       alarm_ack = 1'b0;
  logic       clear_total = 1'b0;

  logic       ready_a, alarm_a, ldisc_a;
  logic [7:0] item_a, disc_a, theft_a;
  logic [2:0] lupc_a;
  logic       ready_b, alarm_b, ldisc_b;
  logic [1:0] item_b, disc_b, theft_b;
  logic [2:0] lupc_b;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: raw counts, saturation applied only when comparing
  int   m_item, m_disc, m_theft;
  bit   m_alarm;
  int   m_lupc;
  bit   m_ldisc;

  always #5 clk = ~clk;

  upc_checkout dut (
    .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_ready(ready_a),
    .upc(upc), .mark(mark), .alarm_ack(alarm_ack), .clear_total(clear_total),
    .item_count(item_a), .disc_count(disc_a), .theft_count(theft_a),
    .alarm(alarm_a), .last_upc(lupc_a), .last_disc(ldisc_a)
  );

  upc_checkout #(.CNT_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .scan_valid(scan_valid), .scan_ready(ready_b),
    .upc(upc), .mark(mark), .alarm_ack(alarm_ack), .clear_total(clear_total),
    .item_count(item_b), .disc_count(disc_b), .theft_count(theft_b),
    .alarm(alarm_b), .last_upc(lupc_b), .last_disc(ldisc_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_item = 0; m_disc = 0; m_theft = 0;
    m_alarm = 0; m_lupc = 0; m_ldisc = 0;
  endtask

  // predicts the state after the coming edge from the current inputs
  task automatic model_step();
    bit acc;
    acc = scan_valid && !m_alarm;
    if (clear_total && !m_alarm) begin
      m_item = 0; m_disc = 0; m_theft = 0;
    end
    if (acc) begin
      m_lupc  = int'(upc);
      m_ldisc = DISC[upc];
      if (THEFT[upc] && !mark) begin
        m_theft++;
        m_alarm = 1;
      end else begin
        m_item++;
        if (DISC[upc]) m_disc++;
      end
    end else if (m_alarm && alarm_ack) begin
      m_alarm = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".item"},  32'(item_a),  32'(sat(m_item, 255)));
    check({tag, ".disc"},  32'(disc_a),  32'(sat(m_disc, 255)));
    check({tag, ".theft"}, 32'(theft_a), 32'(sat(m_theft, 255)));
    check({tag, ".alarm"}, 32'(alarm_a), 32'(m_alarm));
    check({tag, ".ready"}, 32'(ready_a), 32'(!m_alarm));
    check({tag, ".lupc"},  32'(lupc_a),  32'(m_lupc));
    check({tag, ".ldisc"}, 32'(ldisc_a), 32'(m_ldisc));
    check({tag, ".s_item"},  32'(item_b),  32'(sat(m_item, 3)));
    check({tag, ".s_disc"},  32'(disc_b),  32'(sat(m_disc, 3)));
    check({tag, ".s_theft"}, 32'(theft_b), 32'(sat(m_theft, 3)));
    check({tag, ".s_alarm"}, 32'(alarm_b), 32'(m_alarm));
  endtask

  // drive inputs, advance one edge, compare against the model
  task automatic cycle(input string tag, input bit v, input logic [2:0] u, input bit mk,
                       input bit ack, input bit clr);
    scan_valid = v; upc = u; mark = mk; alarm_ack = ack; clear_total = clr;
    model_step();
    @(posedge clk); #1;
    scan_valid = 0; alarm_ack = 0; clear_total = 0;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    #1 reset_n = 0;
    #2 check_all("reset_async");
    do_reset();
    check_all("post_reset");

    // plain discount sale
    cycle("sale011", 1, 3'b011, 0, 0, 0);
    check("sale011.item_const", 32'(item_a), 32'd1);
    check("sale011.disc_const", 32'(disc_a), 32'd1);

    // theft, ignored scan, ack
    cycle("theft101", 1, 3'b101, 0, 0, 0);
    check("theft101.alarm_const", 32'(alarm_a), 32'd1);
    check("theft101.theft_const", 32'(theft_a), 32'd1);
    cycle("alarm_scan", 1, 3'b011, 1, 0, 0);
    check("alarm_scan.item_const", 32'(item_a), 32'd1);
    cycle("alarm_clr", 0, 3'b000, 0, 0, 1);
    check("alarm_clr.item_const", 32'(item_a), 32'd1);
    cycle("ack", 0, 3'b000, 0, 1, 0);
    check("ack.alarm_const", 32'(alarm_a), 32'd0);
    cycle("idle_ack", 0, 3'b000, 0, 1, 0);

    // marked tagged item is a sale
    cycle("sale101m", 1, 3'b101, 1, 0, 0);
    check("sale101m.item_const", 32'(item_a), 32'd2);
    check("sale101m.disc_const", 32'(disc_a), 32'd2);

    // saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 5; i++) cycle("sat001", 1, 3'b001, 0, 0, 0);
    check("sat001.s_item_const", 32'(item_b), 32'd3);
    check("sat001.s_disc_const", 32'(disc_b), 32'd0);
    check("sat001.item_const", 32'(item_a), 32'd5);

    // clear plus sale in one cycle
    do_reset();
    for (int i = 0; i < 5; i++) cycle("pre110", 1, 3'b110, 0, 0, 0);
    check("pre110.item_const", 32'(item_a), 32'd5);
    cycle("clr_sale", 1, 3'b110, 0, 0, 1);
    check("clr_sale.item_const", 32'(item_a), 32'd1);
    check("clr_sale.disc_const", 32'(disc_a), 32'd1);

    // asynchronous reset in the middle of an alarm
    cycle("theft000", 1, 3'b000, 0, 0, 0);
    check("theft000.alarm_const", 32'(alarm_a), 32'd1);
    #2 reset_n = 0;
    model_reset();
    #1;
    check("midreset.alarm", 32'(alarm_a), 32'd0);
    check("midreset.item", 32'(item_a), 32'd0);
    check("midreset.theft", 32'(theft_a), 32'd0);
    check("midreset.ready", 32'(ready_a), 32'd1);
    check_all("midreset");
    @(negedge clk);
    reset_n = 1;
    cycle("after_rst", 1, 3'b010, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cycle("rand",
            ($urandom_range(0, 1) == 1),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 31) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
